// File: rtl/inference_sequencer_pkg.sv
// rtl/inference_sequencer_pkg.sv - shared types, opcodes, status/error codes and command layout
package inference_pkg;

    localparam int DATA_W    = 19;
    localparam int RES_W     = 4;
    localparam int CFG_W     = 8;
    localparam int READ_LSB  = 0;
    localparam int COUNT_LSB = 10;

    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_INFO  = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_BAD_CFG   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
    localparam logic [1:0] ERR_NO_RESULT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        REPORT
    } seq_state_e;

    function automatic logic [DATA_W-1:0] build_cmd(input logic [CFG_W-1:0] rd,
                                                    input logic [CFG_W-1:0] cnt);
        logic [DATA_W-1:0] cmd;
        cmd = '0;
        cmd[READ_LSB +: CFG_W]  = rd;
        cmd[COUNT_LSB +: CFG_W] = cnt;
        return cmd;
    endfunction

endpackage

// File: rtl/inference_sequencer_if.sv
// rtl/inference_sequencer_if.sv - host, sample stream, wrapper and result signals of the sequencer
interface inference_sequencer_if;
    import inference_pkg::*;

    logic              start_i;
    logic [CFG_W-1:0]  cfg_words_i;
    logic [CFG_W-1:0]  cfg_read_i;
    logic [CFG_W-1:0]  cfg_count_i;
    logic [DATA_W-1:0] s_data_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [1:0]        op_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        status_i;
    logic [RES_W-1:0]  result_i;
    logic [RES_W-1:0]  res_o;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [1:0]        err_o;
    logic              busy_o;

    // Sequencer side
    modport master (
        input  start_i, cfg_words_i, cfg_read_i, cfg_count_i,
        input  s_data_i, s_valid_i, status_i, result_i, res_ready_i,
        output s_ready_o, op_o, data_o, res_o, res_valid_o, err_o, busy_o
    );

    // Host, stream source and wrapper side
    modport slave (
        output start_i, cfg_words_i, cfg_read_i, cfg_count_i,
        output s_data_i, s_valid_i, status_i, result_i, res_ready_i,
        input  s_ready_o, op_o, data_o, res_o, res_valid_o, err_o, busy_o
    );

endinterface

// File: rtl/inference_sequencer_seq_timeout.sv
// rtl/inference_sequencer_seq_timeout.sv - clearable up-counter flagging the last allowed wait cycle
module seq_timeout #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q, count_d;

    // done marks the LIMIT-th cycle since clear, so the caller exits on that edge
    assign done_o = (count_q == W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !done_o) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/inference_sequencer.sv
// rtl/inference_sequencer.sv - streams a frame into the classifier wrapper, issues info, returns the class
module inference_sequencer
    import inference_pkg::*;
#(
    parameter int MEM_DEPTH = 128,
    parameter int TIMEOUT   = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    inference_sequencer_if.master bus
);

    seq_state_e        state_q, state_d;
    logic [CFG_W-1:0]  words_q, words_d;
    logic [CFG_W-1:0]  read_q, read_d;
    logic [CFG_W-1:0]  count_q, count_d;
    logic [CFG_W-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [1:0]        err_q, err_d;
    logic              bad_cfg;
    logic              in_wait;
    logic              tmo_done;

    assign bad_cfg = (bus.cfg_words_i == '0)
                  || (int'(bus.cfg_words_i) > MEM_DEPTH)
                  || (bus.cfg_count_i == '0)
                  || (({1'b0, bus.cfg_read_i} + {1'b0, bus.cfg_count_i}) > 9'd255);

    assign in_wait = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

    // One counter serves both waits; any state change restarts it
    seq_timeout #(.LIMIT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_d != state_q),
        .en_i   (in_wait),
        .done_o (tmo_done)
    );

    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        read_d     = read_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        op_d       = OP_IDLE;
        data_d     = '0;
        res_d      = res_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    words_d    = bus.cfg_words_i;
                    read_d     = bus.cfg_read_i;
                    count_d    = bus.cfg_count_i;
                    word_cnt_d = '0;
                    if (bad_cfg) begin
                        state_d = REPORT;
                        err_d   = ERR_BAD_CFG;
                        res_d   = '0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.s_valid_i) begin
                    op_d       = OP_WRITE;
                    data_d     = bus.s_data_i;
                    word_cnt_d = word_cnt_q + CFG_W'(1);
                    if (word_cnt_d == words_q) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                op_d    = OP_INFO;
                data_d  = build_cmd(read_q, count_q);
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.status_i == ST_BUSY) begin
                    state_d = WAIT_DONE;
                end else if (tmo_done) begin
                    state_d = REPORT;
                    err_d   = ERR_TIMEOUT;
                    res_d   = '0;
                end
            end
            WAIT_DONE: begin
                if (bus.status_i != ST_BUSY) begin
                    state_d = REPORT;
                    if (bus.status_i == ST_DONE) begin
                        err_d = ERR_OK;
                        res_d = bus.result_i;
                    end else begin
                        err_d = ERR_NO_RESULT;
                        res_d = '0;
                    end
                end else if (tmo_done) begin
                    state_d = REPORT;
                    err_d   = ERR_TIMEOUT;
                    res_d   = '0;
                end
            end
            REPORT: begin
                if (bus.res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            words_q    <= '0;
            read_q     <= '0;
            count_q    <= '0;
            word_cnt_q <= '0;
            op_q       <= OP_IDLE;
            data_q     <= '0;
            res_q      <= '0;
            err_q      <= ERR_OK;
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            read_q     <= read_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            op_q       <= op_d;
            data_q     <= data_d;
            res_q      <= res_d;
            err_q      <= err_d;
        end
    end

    assign bus.s_ready_o   = (state_q == LOAD);
    assign bus.op_o        = op_q;
    assign bus.data_o      = data_q;
    assign bus.res_o       = res_q;
    assign bus.err_o       = err_q;
    assign bus.res_valid_o = (state_q == REPORT);
    assign bus.busy_o      = (state_q != IDLE);

endmodule
